led_seq_scheduler: RTL

//   Round-robin scheduler sharing one NLED-wide LED bank between NREQ requesters.

---
 rtl/led_seq_pkg.sv | 21 ++
 rtl/led_pattern_gen.sv | 36 +++
 rtl/led_seq_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode codes, FSM states and width helper for the LED sequence scheduler
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FWD    = 2'b00,
    MODE_REV    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Counter width for values 0..v-1, never narrower than one bit
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - combinational LED pattern for one display step
// pos = step mod NLED, bpos = step mod (2*NLED-2), odd = step parity; the caller keeps these as wrap counters.
module led_pattern_gen
  import led_seq_pkg::*;
#(
  parameter int NLED = 5,
  parameter int PW   = 3,
  parameter int BW   = 3
) (
  input  mode_e            mode,
  input  logic [PW-1:0]    pos,
  input  logic [BW-1:0]    bpos,
  input  logic             odd,
  output logic [NLED-1:0]  leds
);

  localparam logic [NLED-1:0] LEFT  = {1'b1, {(NLED-1){1'b0}}};
  localparam logic [NLED-1:0] RIGHT = {{(NLED-1){1'b0}}, 1'b1};

  int b;
  int idx;

  always_comb begin
    leds = '0;
    b    = int'(bpos);
    idx  = (b < NLED) ? b : (2 * NLED - 2 - b);
    case (mode)
      MODE_FWD:    leds = LEFT >> pos;
      MODE_REV:    leds = RIGHT << pos;
      MODE_BOUNCE: leds = LEFT >> idx;
      MODE_BLINK:  leds = odd ? '0 : '1;
      default:     leds = '0;
    endcase
  end

endmodule

// File: rtl/led_seq_scheduler.sv
// rtl/led_seq_scheduler.sv - round-robin owner of a shared LED bank, stepping one pattern per grant
module led_seq_scheduler
  import led_seq_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int NLED     = 5,
  parameter int STEPS    = 10,
  parameter int TICK_DIV = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   mode,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [NLED-1:0]     leds,
  output logic                busy
);

  localparam int SW  = clog2_min1(STEPS);
  localparam int PSW = clog2_min1(TICK_DIV);
  localparam int PW  = clog2_min1(NLED);
  localparam int BW  = clog2_min1(2 * NLED - 2);
  localparam int RW  = clog2_min1(NREQ);
  localparam logic [NREQ-1:0] ONE_R = {{(NREQ-1){1'b0}}, 1'b1};

  state_e          state;
  mode_e           cur_mode;
  logic [RW-1:0]   rr, owner, pick;
  logic [PSW-1:0]  presc;
  logic [SW-1:0]   step;
  logic [PW-1:0]   pos, pos_n, pat_pos;
  logic [BW-1:0]   bpos, bpos_n, pat_bpos;
  logic            found, tick, last, abort, pat_odd;
  mode_e           pick_mode, pat_mode;
  logic [NLED-1:0] pat;
  int              cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int j = 0; j < NREQ; j++) begin
      cand = int'(rr) + j;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = RW'(cand);
      end
    end
  end

  assign pick_mode = mode_e'(mode[2*pick +: 2]);
  assign tick      = (presc == PSW'(TICK_DIV - 1));
  assign last      = (step == SW'(STEPS - 1));
  assign abort     = ((req & gnt) == '0);
  assign pos_n     = (pos == PW'(NLED - 1)) ? '0 : pos + PW'(1);
  assign bpos_n    = (bpos == BW'(2 * NLED - 3)) ? '0 : bpos + BW'(1);

  // Pattern is looked up one step ahead so the registered leds change on the tick edge
  always_comb begin
    pat_mode = cur_mode;
    pat_pos  = pos_n;
    pat_bpos = bpos_n;
    pat_odd  = ~step[0];
    if (state == ST_IDLE) begin
      pat_mode = pick_mode;
      pat_pos  = '0;
      pat_bpos = '0;
      pat_odd  = 1'b0;
    end
  end

  led_pattern_gen #(.NLED(NLED), .PW(PW), .BW(BW)) u_pattern (
    .mode (pat_mode),
    .pos  (pat_pos),
    .bpos (pat_bpos),
    .odd  (pat_odd),
    .leds (pat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur_mode <= MODE_FWD;
      rr       <= '0;
      owner    <= '0;
      presc    <= '0;
      step     <= '0;
      pos      <= '0;
      bpos     <= '0;
      gnt      <= '0;
      done     <= '0;
      leds     <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          // The cycle carrying a done pulse is a mandatory gap before the next grant
          if (found && done == '0) begin
            state    <= ST_RUN;
            gnt      <= ONE_R << pick;
            owner    <= pick;
            cur_mode <= pick_mode;
            presc    <= '0;
            step     <= '0;
            pos      <= '0;
            bpos     <= '0;
            leds     <= pat;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort || (tick && last)) begin
            state <= ST_IDLE;
            done  <= abort ? '0 : gnt;
            gnt   <= '0;
            leds  <= '0;
            busy  <= 1'b0;
            rr    <= (owner == RW'(NREQ - 1)) ? '0 : owner + RW'(1);
          end else if (tick) begin
            presc <= '0;
            step  <= step + SW'(1);
            pos   <= pos_n;
            bpos  <= bpos_n;
            leds  <= pat;
          end else begin
            presc <= presc + PSW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
